// File: rtl/rob_commit.sv
// Reorder buffer with in-order single-entry commit, retirement RAT upkeep,
// and mispredict recovery (squash walk, then rename RAT restore).
module rob_commit #(
  parameter int ROB_ADDRWIDTH    = 6,
  parameter int PHYSREGS_DEPTH   = 6,
  parameter int RENROB_DATAWIDTH = 183,
  parameter int ARCH_REGS        = 32
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                FREEZE,
  input  logic                                tROB_pushReq_IN,
  input  logic [RENROB_DATAWIDTH-1:0]         tROB_pushData_IN,
  output logic                                fROB_full_OUT,
  output logic [ROB_ADDRWIDTH-1:0]            fROB_curTail_OUT,
  input  logic                                cpl_valid_IN,
  input  logic [ROB_ADDRWIDTH-1:0]            cpl_idx_IN,
  input  logic                                cpl_mispred_IN,
  input  logic [31:0]                         cpl_target_IN,
  output logic                                tFreeL_pushReq_OUT,
  output logic [PHYSREGS_DEPTH-1:0]           tFreeL_pushData_OUT,
  output logic                                tRenRatOverwrite_OUT,
  output logic [PHYSREGS_DEPTH*ARCH_REGS-1:0] tRenRatOverwriteData_OUT,
  output logic                                flush_OUT,
  output logic                                redirect_OUT,
  output logic [31:0]                         redirectPC_OUT,
  output logic                                commit_valid_OUT
);
  localparam int DEPTH = 1 << ROB_ADDRWIDTH;
  localparam int AREGW = $clog2(ARCH_REGS);

  typedef enum logic [1:0] {RUN, WALK, RESTORE} state_t;

  state_t                    state_reg, state_next;
  logic [ROB_ADDRWIDTH-1:0]  head_reg, tail_reg, walk_reg;
  logic [ROB_ADDRWIDTH-1:0]  head_inc, walk_inc;
  logic [ROB_ADDRWIDTH:0]    count_reg;
  logic [DEPTH-1:0]          valid_reg;

  logic                      done_mem    [DEPTH];
  logic                      mispred_mem [DEPTH];
  logic                      dreq_mem    [DEPTH];
  logic [AREGW-1:0]          arch_mem    [DEPTH];
  logic [PHYSREGS_DEPTH-1:0] phys_mem    [DEPTH];
  logic [31:0]               target_mem  [DEPTH];
  logic [PHYSREGS_DEPTH-1:0] ret_rat_reg [ARCH_REGS];

  logic full, push_ok, cpl_ok, commit_fire, walk_fire, restore_fire;
  logic unused_bits;

  // Only the dest-reqd, phys/arch dest fields of the rename payload matter here.
  assign unused_bits = ^tROB_pushData_IN;

  assign head_inc         = head_reg + 1'b1;
  assign walk_inc         = walk_reg + 1'b1;
  assign full             = (count_reg == (ROB_ADDRWIDTH+1)'(DEPTH)) || (state_reg != RUN);
  assign fROB_full_OUT    = full;
  assign fROB_curTail_OUT = tail_reg;

  genvar gi;
  generate
    for (gi = 0; gi < ARCH_REGS; gi++) begin : g_rat_out
      assign tRenRatOverwriteData_OUT[gi*PHYSREGS_DEPTH +: PHYSREGS_DEPTH] = ret_rat_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    commit_fire  = 1'b0;
    walk_fire    = 1'b0;
    restore_fire = 1'b0;
    case (state_reg)
      RUN: begin
        commit_fire = (count_reg != '0) && valid_reg[head_reg] && done_mem[head_reg] && !FREEZE;
        if (commit_fire && mispred_mem[head_reg])
          state_next = (head_inc == tail_reg) ? RESTORE : WALK;
      end
      WALK: begin
        if (!FREEZE) begin
          walk_fire = 1'b1;
          if (walk_inc == tail_reg) state_next = RESTORE;
        end
      end
      RESTORE: begin
        if (!FREEZE) begin
          restore_fire = 1'b1;
          state_next   = RUN;
        end
      end
      default: state_next = RUN;
    endcase
    // A mispredicting commit squashes anything renamed in the same cycle.
    push_ok = tROB_pushReq_IN && !full && !(commit_fire && mispred_mem[head_reg]);
    cpl_ok  = (state_reg == RUN) && cpl_valid_IN && valid_reg[cpl_idx_IN];
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      done_mem[tail_reg] <= 1'b0;
      dreq_mem[tail_reg] <= tROB_pushData_IN[149];
      phys_mem[tail_reg] <= tROB_pushData_IN[92:87];
      arch_mem[tail_reg] <= tROB_pushData_IN[38:34];
    end
    if (cpl_ok) begin
      done_mem[cpl_idx_IN]    <= 1'b1;
      mispred_mem[cpl_idx_IN] <= cpl_mispred_IN;
      target_mem[cpl_idx_IN]  <= cpl_target_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg            <= RUN;
      head_reg             <= '0;
      tail_reg             <= '0;
      walk_reg             <= '0;
      count_reg            <= '0;
      valid_reg            <= '0;
      tFreeL_pushReq_OUT   <= 1'b0;
      tFreeL_pushData_OUT  <= '0;
      tRenRatOverwrite_OUT <= 1'b0;
      flush_OUT            <= 1'b0;
      redirect_OUT         <= 1'b0;
      redirectPC_OUT       <= '0;
      commit_valid_OUT     <= 1'b0;
      for (int i = 0; i < ARCH_REGS; i++) ret_rat_reg[i] <= i[PHYSREGS_DEPTH-1:0];
    end else begin
      state_reg            <= state_next;
      tFreeL_pushReq_OUT   <= 1'b0;
      tFreeL_pushData_OUT  <= '0;
      tRenRatOverwrite_OUT <= 1'b0;
      flush_OUT            <= 1'b0;
      redirect_OUT         <= 1'b0;
      redirectPC_OUT       <= '0;
      commit_valid_OUT     <= commit_fire;

      if (push_ok) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + 1'b1;
      end

      case ({push_ok, commit_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (commit_fire) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_inc;
        if (dreq_mem[head_reg]) begin
          // The previous mapping of this arch reg is now dead.
          tFreeL_pushReq_OUT             <= 1'b1;
          tFreeL_pushData_OUT            <= ret_rat_reg[arch_mem[head_reg]];
          ret_rat_reg[arch_mem[head_reg]] <= phys_mem[head_reg];
        end
        if (mispred_mem[head_reg]) begin
          flush_OUT      <= 1'b1;
          redirect_OUT   <= 1'b1;
          redirectPC_OUT <= target_mem[head_reg];
          walk_reg       <= head_inc;
        end
      end

      if (walk_fire) begin
        valid_reg[walk_reg] <= 1'b0;
        walk_reg            <= walk_inc;
        if (dreq_mem[walk_reg]) begin
          tFreeL_pushReq_OUT  <= 1'b1;
          tFreeL_pushData_OUT <= phys_mem[walk_reg];
        end
      end

      if (restore_fire) begin
        tRenRatOverwrite_OUT <= 1'b1;
        tail_reg             <= head_reg;
        count_reg            <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: in-order commit, full handling, mispredict
// walk/restore, freeze during walk and reset during walk.
module tb_rob_commit;
  logic         CLK = 1'b0;
  logic         RESET, FREEZE;
  logic         push_req;
  logic [182:0] push_data;
  logic         full;
  logic [5:0]   cur_tail;
  logic         cpl_valid;
  logic [5:0]   cpl_idx;
  logic         cpl_mispred;
  logic [31:0]  cpl_target;
  logic         fl_push;
  logic [5:0]   fl_data;
  logic         rat_ow;
  logic [191:0] rat_data;
  logic         flush, redirect, commit_valid;
  logic [31:0]  redirect_pc;

  int total = 0;
  int bad = 0;
  int fl_cnt = 0;
  int c0;
  logic [191:0] ident, exp_rat;

  always #5 CLK = ~CLK;

  rob_commit dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
    .tROB_pushReq_IN(push_req), .tROB_pushData_IN(push_data),
    .fROB_full_OUT(full), .fROB_curTail_OUT(cur_tail),
    .cpl_valid_IN(cpl_valid), .cpl_idx_IN(cpl_idx),
    .cpl_mispred_IN(cpl_mispred), .cpl_target_IN(cpl_target),
    .tFreeL_pushReq_OUT(fl_push), .tFreeL_pushData_OUT(fl_data),
    .tRenRatOverwrite_OUT(rat_ow), .tRenRatOverwriteData_OUT(rat_data),
    .flush_OUT(flush), .redirect_OUT(redirect), .redirectPC_OUT(redirect_pc),
    .commit_valid_OUT(commit_valid)
  );

  always @(posedge CLK) if (fl_push) fl_cnt++;

  function automatic logic [182:0] mk(input logic dreq, input logic [4:0] arch,
                                      input logic [5:0] phys);
    logic [182:0] d;
    d = '0;
    d[149]   = dreq;
    d[92:87] = phys;
    d[38:34] = arch;
    d[86:55] = 32'h0040_0000 + {21'd0, arch, 6'd0};
    return d;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    cyc();
    RESET = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b0; FREEZE = 1'b0; push_req = 1'b0; push_data = '0;
    cpl_valid = 1'b0; cpl_idx = '0; cpl_mispred = 1'b0; cpl_target = '0;
    for (int i = 0; i < 32; i++) ident[i*6 +: 6] = i[5:0];
    repeat (2) cyc();
    RESET = 1'b1;

    // reset state
    chk("rst_full", full, 0);
    chk("rst_tail", cur_tail, 0);
    chk("rst_flpush", fl_push, 0);
    chk("rst_ow", rat_ow, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redir", redirect, 0);
    chk("rst_commit", commit_valid, 0);
    chk("rst_rat", rat_data, ident);

    // three pushes, completed in reverse order
    push_req = 1'b1; push_data = mk(1, 5, 32); cyc();
    chk("t1_tail1", cur_tail, 1);
    push_data = mk(1, 6, 33); cyc();
    push_data = mk(0, 0, 7);  cyc();
    push_req = 1'b0;
    chk("t1_tail3", cur_tail, 3);
    cpl_valid = 1'b1; cpl_idx = 2; cyc();
    cpl_idx = 1; cyc();
    chk("t1_nocommit_a", commit_valid, 0);
    cpl_idx = 0; cyc();
    chk("t1_nocommit_b", commit_valid, 0);
    cpl_valid = 1'b0;
    exp_rat = ident; exp_rat[5*6 +: 6] = 6'd32;
    cyc();
    chk("t1_c0_valid", commit_valid, 1);
    chk("t1_c0_fl", fl_push, 1);
    chk("t1_c0_fldata", fl_data, 5);
    chk("t1_c0_rat", rat_data, exp_rat);
    exp_rat[6*6 +: 6] = 6'd33;
    cyc();
    chk("t1_c1_valid", commit_valid, 1);
    chk("t1_c1_fl", fl_push, 1);
    chk("t1_c1_fldata", fl_data, 6);
    chk("t1_c1_rat", rat_data, exp_rat);
    cyc();
    chk("t1_c2_valid", commit_valid, 1);
    chk("t1_c2_fl", fl_push, 0);
    cyc();
    chk("t1_idle", commit_valid, 0);

    // fill all 64 entries
    do_reset();
    chk("t2_rst_tail", cur_tail, 0);
    chk("t2_rst_rat", rat_data, ident);
    push_req = 1'b1;
    for (int i = 0; i < 64; i++) begin
      push_data = mk(0, i[4:0], i[5:0]);
      cyc();
    end
    chk("t2_full", full, 1);
    chk("t2_tail", cur_tail, 0);
    push_data = mk(1, 1, 60); cyc();
    push_req = 1'b0;
    chk("t2_65th_tail", cur_tail, 0);
    chk("t2_65th_full", full, 1);
    cpl_valid = 1'b1; cpl_idx = 0; cyc();
    cpl_valid = 1'b0;
    chk("t2_cpl_full", full, 1);
    cyc();
    chk("t2_commit", commit_valid, 1);
    chk("t2_notfull", full, 0);
    chk("t2_tail0", cur_tail, 0);
    push_req = 1'b1; push_data = mk(0, 0, 0); cyc();
    push_req = 1'b0;
    chk("t2_push_at0", cur_tail, 1);
    chk("t2_refull", full, 1);

    // 63 entries: commit and push on the same edge
    cpl_valid = 1'b1; cpl_idx = 1; cyc();
    cpl_valid = 1'b0; cyc();
    chk("t3_63", full, 0);
    cpl_valid = 1'b1; cpl_idx = 2; cyc();
    cpl_valid = 1'b0;
    chk("t3_cpl_full", full, 0);
    push_req = 1'b1; push_data = mk(0, 3, 3); cyc();
    chk("t3_commit", commit_valid, 1);
    chk("t3_still63", full, 0);
    chk("t3_tail2", cur_tail, 2);
    cyc();
    push_req = 1'b0;
    chk("t3_64", full, 1);
    chk("t3_tail3", cur_tail, 3);

    // mispredict with four younger entries
    do_reset();
    push_req = 1'b1; push_data = mk(1, 9, 20); cyc();
    push_req = 1'b0;
    cpl_valid = 1'b1; cpl_idx = 0; cyc();
    cpl_valid = 1'b0;
    exp_rat = ident; exp_rat[9*6 +: 6] = 6'd20;
    cyc();
    chk("t4_pre_commit", commit_valid, 1);
    chk("t4_pre_fldata", fl_data, 9);
    chk("t4_pre_rat", rat_data, exp_rat);
    push_req = 1'b1;
    push_data = mk(0, 0, 0);  cyc();
    push_data = mk(1, 3, 40); cyc();
    push_data = mk(1, 4, 41); cyc();
    push_data = mk(1, 7, 42); cyc();
    push_data = mk(0, 8, 1);  cyc();
    push_req = 1'b0;
    cpl_valid = 1'b1; cpl_idx = 1; cpl_mispred = 1'b1; cpl_target = 32'h0040_0100; cyc();
    cpl_valid = 1'b0; cpl_mispred = 1'b0;
    push_req = 1'b1; push_data = mk(1, 2, 50); cyc();
    push_req = 1'b0;
    chk("t4_commit", commit_valid, 1);
    chk("t4_flush", flush, 1);
    chk("t4_redir", redirect, 1);
    chk("t4_redir_pc", redirect_pc, 32'h0040_0100);
    chk("t4_br_fl", fl_push, 0);
    chk("t4_full", full, 1);
    c0 = fl_cnt;
    cyc();
    chk("t4_flush_pulse", flush, 0);
    chk("t4_walk0_fl", fl_push, 1);
    chk("t4_walk0_data", fl_data, 40);
    cyc();
    chk("t4_walk1_data", fl_data, 41);
    cyc();
    chk("t4_walk2_data", fl_data, 42);
    cyc();
    chk("t4_walk3_fl", fl_push, 0);
    chk("t4_walk3_ow", rat_ow, 0);
    chk("t4_walk3_full", full, 1);
    cyc();
    chk("t4_ow", rat_ow, 1);
    chk("t4_ow_data", rat_data, exp_rat);
    chk("t4_ow_full", full, 0);
    chk("t4_ow_tail", cur_tail, 2);
    cyc();
    chk("t4_ow_pulse", rat_ow, 0);
    chk("t4_fl_total", fl_cnt - c0, 3);

    // freeze for 3 cycles in the middle of a walk
    push_req = 1'b1;
    push_data = mk(0, 0, 0);   cyc();
    push_data = mk(1, 10, 43); cyc();
    push_data = mk(1, 11, 44); cyc();
    push_data = mk(1, 12, 45); cyc();
    push_req = 1'b0;
    cpl_valid = 1'b1; cpl_idx = 2; cpl_mispred = 1'b1; cpl_target = 32'h0050_0000; cyc();
    cpl_valid = 1'b0; cpl_mispred = 1'b0;
    cyc();
    chk("t5_flush", flush, 1);
    chk("t5_redir_pc", redirect_pc, 32'h0050_0000);
    c0 = fl_cnt;
    cyc();
    chk("t5_walk0_data", fl_data, 43);
    FREEZE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_frz_fl", fl_push, 0);
      chk("t5_frz_ow", rat_ow, 0);
    end
    FREEZE = 1'b0;
    cyc();
    chk("t5_resume_fl", fl_push, 1);
    chk("t5_resume_data", fl_data, 44);
    cyc();
    chk("t5_walk2_data", fl_data, 45);
    cyc();
    chk("t5_ow", rat_ow, 1);
    chk("t5_ow_data", rat_data, exp_rat);
    chk("t5_tail", cur_tail, 3);
    chk("t5_fl_total", fl_cnt - c0, 3);

    // reset while walking
    push_req = 1'b1;
    push_data = mk(0, 0, 0);   cyc();
    push_data = mk(1, 13, 46); cyc();
    push_data = mk(1, 14, 47); cyc();
    push_data = mk(1, 15, 48); cyc();
    push_req = 1'b0;
    cpl_valid = 1'b1; cpl_idx = 3; cpl_mispred = 1'b1; cpl_target = 32'h0060_0000; cyc();
    cpl_valid = 1'b0; cpl_mispred = 1'b0;
    cyc();
    chk("t6_flush", flush, 1);
    cyc();
    chk("t6_walk0_data", fl_data, 46);
    RESET = 1'b0; cyc(); RESET = 1'b1;
    chk("t6_rst_fl", fl_push, 0);
    chk("t6_rst_flush", flush, 0);
    chk("t6_rst_redir", redirect, 0);
    chk("t6_rst_pc", redirect_pc, 0);
    chk("t6_rst_ow", rat_ow, 0);
    chk("t6_rst_commit", commit_valid, 0);
    chk("t6_rst_full", full, 0);
    chk("t6_rst_tail", cur_tail, 0);
    chk("t6_rst_rat", rat_data, ident);
    c0 = fl_cnt;
    cyc();
    chk("t6_post_fl", fl_push, 0);
    push_req = 1'b1; push_data = mk(0, 1, 1); cyc();
    push_req = 1'b0;
    chk("t6_push_tail", cur_tail, 1);
    chk("t6_push_full", full, 0);
    cyc();
    chk("t6_no_commit", commit_valid, 0);
    chk("t6_fl_total", fl_cnt - c0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
